// File: rtl/exec_unit_if.sv
// Handshake and register-file bus between the instruction controller and
// register file (master side) and the exec_unit execute stage (slave side).
interface exec_unit_if #(
  parameter int W = 16
);
  logic         start;
  logic [1:0]   op;
  logic [1:0]   shift;
  logic [2:0]   rd;
  logic [2:0]   rn;
  logic [2:0]   rm;
  logic [W-1:0] rf_a;
  logic [W-1:0] rf_b;
  logic [2:0]   rf_reg_a;
  logic [2:0]   rf_reg_b;
  logic [2:0]   rf_reg_w;
  logic [W-1:0] rf_data_in;
  logic         rf_write;
  logic         busy;
  logic         done;
  logic [2:0]   status;

  modport master (
    output start, op, shift, rd, rn, rm, rf_a, rf_b,
    input  rf_reg_a, rf_reg_b, rf_reg_w, rf_data_in, rf_write, busy, done, status
  );

  modport slave (
    input  start, op, shift, rd, rn, rm, rf_a, rf_b,
    output rf_reg_a, rf_reg_b, rf_reg_w, rf_data_in, rf_write, busy, done, status
  );
endinterface

// File: rtl/exec_unit.sv
// Multi-cycle execute stage: IDLE -> LOAD -> EXEC -> WB, one operation at a time.
// Operands are read from the register file in LOAD, the shifted ALU result lands in C in EXEC.
module exec_unit #(
  parameter int W = 16
) (
  input  logic       clk,
  input  logic       reset,
  exec_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_MVN  = 2'b11;
  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  state_t       state_q, state_d;
  logic [1:0]   op_q, op_d;
  logic [1:0]   shift_q, shift_d;
  logic [2:0]   rd_q, rd_d;
  logic [2:0]   rn_q, rn_d;
  logic [2:0]   rm_q, rm_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] c_q, c_d;
  logic [2:0]   status_q, status_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         rf_write_q, rf_write_d;

  logic [W-1:0] bs_s;
  logic [W-1:0] alu_res_s;
  logic [2:0]   cmp_flags_s;

  always_comb begin
    bs_s = b_q;
    case (shift_q)
      SH_NONE: bs_s = b_q;
      SH_LSL:  bs_s = {b_q[W-2:0], 1'b0};
      SH_LSR:  bs_s = {1'b0, b_q[W-1:1]};
      SH_ASR:  bs_s = {b_q[W-1], b_q[W-1:1]};
      default: bs_s = b_q;
    endcase
  end

  // Flags are derived from the subtraction result; only CMP commits them.
  always_comb begin
    alu_res_s = '0;
    case (op_q)
      OP_ADD:  alu_res_s = a_q + bs_s;
      OP_CMP:  alu_res_s = a_q - bs_s;
      OP_AND:  alu_res_s = a_q & bs_s;
      OP_MVN:  alu_res_s = ~bs_s;
      default: alu_res_s = '0;
    endcase
    cmp_flags_s = {(alu_res_s == '0),
                   alu_res_s[W-1],
                   (a_q[W-1] != bs_s[W-1]) && (alu_res_s[W-1] != a_q[W-1])};
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    shift_d    = shift_q;
    rd_d       = rd_q;
    rn_d       = rn_q;
    rm_d       = rm_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    status_d   = status_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rf_write_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d    = bus.op;
          shift_d = bus.shift;
          rd_d    = bus.rd;
          rn_d    = bus.rn;
          rm_d    = bus.rm;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        a_d     = bus.rf_a;
        b_d     = bus.rf_b;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        c_d = alu_res_s;
        if (op_q == OP_CMP) begin
          status_d = cmp_flags_s;
        end else begin
          status_d = status_q;
        end
        // done/rf_write are registered, so they are set on the way into WB.
        done_d     = 1'b1;
        rf_write_d = (op_q != OP_CMP);
        state_d    = S_WB;
      end
      S_WB: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= 2'b00;
      shift_q    <= 2'b00;
      rd_q       <= 3'b000;
      rn_q       <= 3'b000;
      rm_q       <= 3'b000;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      status_q   <= 3'b000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rf_write_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      shift_q    <= shift_d;
      rd_q       <= rd_d;
      rn_q       <= rn_d;
      rm_q       <= rm_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      status_q   <= status_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rf_write_q <= rf_write_d;
    end
  end

  assign bus.rf_reg_a   = rn_q;
  assign bus.rf_reg_b   = rm_q;
  assign bus.rf_reg_w   = rd_q;
  assign bus.rf_data_in = c_q;
  assign bus.rf_write   = rf_write_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.status     = status_q;

endmodule

// File: tb/tb_exec_unit.sv
// Bench for exec_unit: directed scenarios plus randomized operations against an
// arithmetic reference model, with a small register-file model on the bus.
module tb_exec_unit;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  int   write_cnt = 0;
  logic [2:0] exp_status;

  logic [15:0] regs [8];
  logic        pre_we = 1'b0;
  logic [2:0]  pre_addr = 3'd0;
  logic [15:0] pre_data = 16'h0000;

  exec_unit_if #(.W(W)) bus ();

  exec_unit #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.rf_a = regs[bus.rf_reg_a];
  assign bus.rf_b = regs[bus.rf_reg_b];

  // Register file model: preload port for the bench, write port for the DUT.
  always @(posedge clk) begin
    if (pre_we) begin
      regs[pre_addr] <= pre_data;
    end else if (bus.rf_write) begin
      regs[bus.rf_reg_w] <= bus.rf_data_in;
      write_cnt <= write_cnt + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reg(input logic [2:0] a, input logic [15:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    step();
    pre_we = 1'b0;
  endtask

  // Leaves the bench in the LOAD cycle of the accepted operation.
  task automatic issue(input logic [1:0] op, input logic [1:0] sh,
                       input logic [2:0] rd, input logic [2:0] rn, input logic [2:0] rm);
    bus.op = op; bus.shift = sh; bus.rd = rd; bus.rn = rn; bus.rm = rm;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  function automatic void ref_op(input logic [1:0] op, input logic [1:0] sh,
                                 input logic [15:0] a, input logic [15:0] b,
                                 input logic [2:0] st_in,
                                 output logic [15:0] res, output logic [2:0] st,
                                 output logic wr);
    int ua, ub, bs, r, sa, sb, d;
    ua = int'(a);
    ub = int'(b);
    case (sh)
      2'd1:    bs = (ub * 2) % 65536;
      2'd2:    bs = ub / 2;
      2'd3:    bs = ub / 2 + ((ub >= 32768) ? 32768 : 0);
      default: bs = ub;
    endcase
    st = st_in;
    wr = (op != 2'd1);
    case (op)
      2'd0:    r = (ua + bs) % 65536;
      2'd1:    r = (ua - bs + 65536) % 65536;
      2'd2:    r = ua & bs;
      default: r = 65535 - bs;
    endcase
    res = 16'(r);
    if (op == 2'd1) begin
      sa = (ua >= 32768) ? ua - 65536 : ua;
      sb = (bs >= 32768) ? bs - 65536 : bs;
      d  = sa - sb;
      st = {r == 0, r >= 32768, (d > 32767) || (d < -32768)};
    end
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b1; bus.op = 2'd3; bus.shift = 2'd1; bus.rd = 3'd5; bus.rn = 3'd6; bus.rm = 3'd7;
    step();
    step();
    vectors++;
    if ({bus.busy, bus.done, bus.rf_write} !== 3'b000) begin
      $display("FAIL reset_ctrl: got %b expected 000", {bus.busy, bus.done, bus.rf_write});
      miscompares++;
    end
    vectors++;
    if ({bus.rf_reg_a, bus.rf_reg_b, bus.rf_reg_w, bus.rf_data_in, bus.status} !== 28'h0) begin
      $display("FAIL reset_data: got %h expected 0",
               {bus.rf_reg_a, bus.rf_reg_b, bus.rf_reg_w, bus.rf_data_in, bus.status});
      miscompares++;
    end
    reset = 1'b0;
    bus.start = 1'b0;
    step();
    vectors++;
    if (bus.busy !== 1'b0) begin
      $display("FAIL reset_idle: busy got %b expected 0", bus.busy);
      miscompares++;
    end
    exp_status = 3'b000;
  endtask

  task automatic test_add_lsl();
    set_reg(3'd0, 16'd5);
    set_reg(3'd1, 16'd3);
    issue(2'd0, 2'd1, 3'd2, 3'd0, 3'd1);
    vectors++;
    if ({bus.busy, bus.done, bus.rf_write, bus.rf_reg_a, bus.rf_reg_b} !== {3'b100, 3'd0, 3'd1}) begin
      $display("FAIL add_load: got %b expected %b",
               {bus.busy, bus.done, bus.rf_write, bus.rf_reg_a, bus.rf_reg_b}, {3'b100, 3'd0, 3'd1});
      miscompares++;
    end
    step();
    vectors++;
    if ({bus.busy, bus.done, bus.rf_write} !== 3'b100) begin
      $display("FAIL add_exec: got %b expected 100", {bus.busy, bus.done, bus.rf_write});
      miscompares++;
    end
    step();
    vectors++;
    if ({bus.busy, bus.done, bus.rf_write, bus.rf_reg_w, bus.rf_data_in, bus.status} !==
        {3'b111, 3'd2, 16'h000B, exp_status}) begin
      $display("FAIL add_wb: got %h expected %h",
               {bus.busy, bus.done, bus.rf_write, bus.rf_reg_w, bus.rf_data_in, bus.status},
               {3'b111, 3'd2, 16'h000B, exp_status});
      miscompares++;
    end
    step();
    vectors++;
    if ({bus.busy, bus.done, regs[2]} !== {2'b00, 16'h000B}) begin
      $display("FAIL add_after: got %h expected %h", {bus.busy, bus.done, regs[2]}, {2'b00, 16'h000B});
      miscompares++;
    end
  endtask

  task automatic test_cmp_overflow();
    int dn, wr, wc0;
    set_reg(3'd0, 16'h7FFF);
    set_reg(3'd1, 16'hFFFF);
    wc0 = write_cnt; dn = 0; wr = 0;
    issue(2'd1, 2'd0, 3'd3, 3'd0, 3'd1);
    for (int i = 0; i < 4; i++) begin
      if (bus.done === 1'b1) dn++;
      if (bus.rf_write !== 1'b0) wr++;
      step();
    end
    exp_status = 3'b011;
    vectors++;
    if ({dn, wr, write_cnt - wc0} !== {32'd1, 32'd0, 32'd0}) begin
      $display("FAIL cmp_ovf_pulses: done=%0d writes=%0d expected done=1 writes=0", dn, wr + write_cnt - wc0);
      miscompares++;
    end
    vectors++;
    if (bus.status !== exp_status) begin
      $display("FAIL cmp_ovf_status: got %b expected %b", bus.status, exp_status);
      miscompares++;
    end
  endtask

  task automatic test_cmp_eq_then_add();
    set_reg(3'd3, 16'h1234);
    set_reg(3'd4, 16'h1234);
    issue(2'd1, 2'd0, 3'd0, 3'd3, 3'd4);
    step(); step(); step();
    exp_status = 3'b100;
    vectors++;
    if (bus.status !== exp_status) begin
      $display("FAIL cmp_eq_status: got %b expected %b", bus.status, exp_status);
      miscompares++;
    end
    set_reg(3'd5, 16'h0001);
    issue(2'd0, 2'd0, 3'd0, 3'd5, 3'd5);
    step(); step(); step();
    vectors++;
    if ({regs[0], bus.status} !== {16'h0002, exp_status}) begin
      $display("FAIL add_after_cmp: got %h expected %h", {regs[0], bus.status}, {16'h0002, exp_status});
      miscompares++;
    end
  endtask

  task automatic test_mvn();
    set_reg(3'd6, 16'h8000);
    issue(2'd3, 2'd3, 3'd7, 3'd0, 3'd6);
    step(); step();
    vectors++;
    if ({bus.rf_write, bus.rf_data_in} !== {1'b1, 16'h3FFF}) begin
      $display("FAIL mvn_asr: got %h expected %h", {bus.rf_write, bus.rf_data_in}, {1'b1, 16'h3FFF});
      miscompares++;
    end
    step();
    issue(2'd3, 2'd2, 3'd7, 3'd0, 3'd6);
    step(); step();
    vectors++;
    if ({bus.rf_write, bus.rf_data_in} !== {1'b1, 16'hBFFF}) begin
      $display("FAIL mvn_lsr: got %h expected %h", {bus.rf_write, bus.rf_data_in}, {1'b1, 16'hBFFF});
      miscompares++;
    end
    step();
    vectors++;
    if (regs[7] !== 16'hBFFF) begin
      $display("FAIL mvn_wb: R7 got %h expected BFFF", regs[7]);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    int wc0;
    int done_cyc [$];
    set_reg(3'd2, 16'h0F0F);
    set_reg(3'd3, 16'h00FF);
    set_reg(3'd4, 16'hAAAA);
    set_reg(3'd5, 16'hBBBB);
    set_reg(3'd6, 16'hCCCC);
    wc0 = write_cnt;
    bus.op = 2'd2; bus.shift = 2'd0; bus.rd = 3'd1; bus.rn = 3'd2; bus.rm = 3'd3;
    bus.start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (bus.done === 1'b1) done_cyc.push_back(c);
      if (c <= 3) begin
        bus.rd = 3'(c + 3);
        bus.op = 2'd0;
      end else if (c == 4) begin
        vectors++;
        if ({bus.busy, regs[1], write_cnt - wc0} !== {1'b0, 16'h000F, 32'd1}) begin
          $display("FAIL busy_start_first: busy=%b R1=%h writes=%0d expected busy=0 R1=000f writes=1",
                   bus.busy, regs[1], write_cnt - wc0);
          miscompares++;
        end
        bus.op = 2'd2; bus.rd = 3'd0;
      end else begin
        bus.start = 1'b0;
      end
    end
    vectors++;
    if ({regs[4], regs[5], regs[6]} !== {16'hAAAA, 16'hBBBB, 16'hCCCC}) begin
      $display("FAIL busy_start_ignored: got %h expected aaaabbbbcccc", {regs[4], regs[5], regs[6]});
      miscompares++;
    end
    vectors++;
    if (done_cyc.size() != 2 || done_cyc[0] != 3 || done_cyc[1] != 7 || regs[0] !== 16'h000F) begin
      $display("FAIL busy_spacing: done pulses=%0d R0=%h expected 2 pulses 4 cycles apart R0=000f",
               done_cyc.size(), regs[0]);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid_exec();
    int wc0;
    set_reg(3'd0, 16'h0001);
    set_reg(3'd1, 16'h0002);
    issue(2'd1, 2'd0, 3'd2, 3'd0, 3'd1);
    step(); step(); step();
    exp_status = 3'b010;
    vectors++;
    if (bus.status !== exp_status) begin
      $display("FAIL rst_pre_status: got %b expected %b", bus.status, exp_status);
      miscompares++;
    end
    wc0 = write_cnt;
    issue(2'd0, 2'd0, 3'd2, 3'd0, 3'd1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_status = 3'b000;
    vectors++;
    if ({bus.busy, bus.done, bus.rf_write, bus.status, bus.rf_reg_w} !== 9'b0) begin
      $display("FAIL rst_mid_exec: got %b expected 0",
               {bus.busy, bus.done, bus.rf_write, bus.status, bus.rf_reg_w});
      miscompares++;
    end
    step(); step(); step();
    vectors++;
    if (write_cnt !== wc0) begin
      $display("FAIL rst_no_write: writes got %0d expected %0d", write_cnt, wc0);
      miscompares++;
    end
    issue(2'd0, 2'd0, 3'd2, 3'd0, 3'd1);
    step(); step(); step();
    vectors++;
    if ({regs[2], write_cnt - wc0} !== {16'h0003, 32'd1}) begin
      $display("FAIL rst_fresh_op: R2=%h writes=%0d expected 0003 1", regs[2], write_cnt - wc0);
      miscompares++;
    end
  endtask

  task automatic test_random();
    logic [1:0]  op, sh;
    logic [2:0]  rd, rn, rm, st;
    logic [15:0] res;
    logic        wr;
    for (int i = 0; i < 8; i++) set_reg(3'(i), 16'($urandom));
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 0) set_reg(3'($urandom_range(0, 7)), 16'($urandom));
      if ($urandom_range(0, 3) == 0) set_reg(3'($urandom_range(0, 7)), 16'h8000);
      op = 2'($urandom_range(0, 3)); sh = 2'($urandom_range(0, 3));
      rd = 3'($urandom_range(0, 7)); rn = 3'($urandom_range(0, 7)); rm = 3'($urandom_range(0, 7));
      ref_op(op, sh, regs[rn], regs[rm], exp_status, res, st, wr);
      issue(op, sh, rd, rn, rm);
      for (int k = 0; k < 2; k++) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.op = 2'($urandom); bus.shift = 2'($urandom);
        bus.rd = 3'($urandom); bus.rn = 3'($urandom); bus.rm = 3'($urandom);
        step();
      end
      exp_status = st;
      vectors++;
      if ({bus.done, bus.rf_write, bus.rf_reg_w, bus.rf_data_in, bus.status} !== {1'b1, wr, rd, res, st}) begin
        $display("FAIL rand_wb[%0d] op=%0d sh=%0d: got %h expected %h", n, op, sh,
                 {bus.done, bus.rf_write, bus.rf_reg_w, bus.rf_data_in, bus.status},
                 {1'b1, wr, rd, res, st});
        miscompares++;
      end
      bus.start = 1'($urandom_range(0, 1));
      step();
      bus.start = 1'b0;
      vectors++;
      if ({bus.busy, bus.done, bus.rf_write} !== 3'b000) begin
        $display("FAIL rand_idle[%0d]: got %b expected 000", n, {bus.busy, bus.done, bus.rf_write});
        miscompares++;
      end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 2'd0; bus.shift = 2'd0;
    bus.rd = 3'd0; bus.rn = 3'd0; bus.rm = 3'd0;
    exp_status = 3'b000;
    reset = 1'b1;
    #1;
    test_reset();
    test_add_lsl();
    test_cmp_overflow();
    test_cmp_eq_then_add();
    test_mvn();
    test_back_to_back();
    test_reset_mid_exec();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
